// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the data-side bus arbiter: FSM states, owner encoding, latched request payload.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_t;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  // Payload captured from the winning master in IDLE and replayed on the bus in ISSUE.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } bus_req_t;

  // M1 wins when it is the only requester, or when it has aged out against M0.
  function automatic logic pick_m1(input logic m0_req, input logic m1_req, input logic age_sat);
    return m1_req && (!m0_req || age_sat);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_age_counter.sv
// Saturating starvation counter for the low-priority master.
// Latency: count updates one cycle after inc/clr; sat is combinational from the count.
// Backpressure: none; clr has priority over inc, inc is ignored once saturated.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   inc, clr    increment / clear requests
//   count       current age
//   sat         count has reached MAX_WAIT
module arb_age_counter #(
  parameter  int MAX_WAIT = 8,
  localparam int W        = $clog2(MAX_WAIT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  assign sat = (count == W'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the data-side decoder bus: M0 (CPU MEM) fixed priority, M1 aged in after MAX_WAIT losses.
// Latency: request sampled in IDLE at N -> bus_valid at N+1 -> one-cycle ack with registered rdata at N+2.
// Backpressure: none; one transaction per 3 cycles, payload latched at grant, masters must drop req on ack.
//
// Ports:
//   clk, reset                      clock, asynchronous active-low reset (0 = reset)
//   m{0,1}_req/addr/wdata/byteen    master requests (byteen 0 = read)
//   m{0,1}_ack/rdata                one-cycle completion pulse, rdata valid only with ack
//   bus_valid/addr/wdata/byteen     decoder-side transaction, all zero outside ISSUE
//   bus_rdata                       decoder read data, sampled during ISSUE
//   bus_owner                       master owning the current ISSUE/RESP (0 = M0, 1 = M1)
//   busy                            arbiter is not IDLE
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteen,
  input  logic [31:0] bus_rdata,
  output logic        bus_owner,
  output logic        busy
);

  localparam int AGE_W = $clog2(MAX_WAIT + 1);

  arb_state_t  state_q, state_d;
  bus_req_t    req_q;
  logic        owner_q;
  logic [31:0] rdata_q;

  logic             in_idle;
  logic             any_req;
  logic             take_m1;
  logic             age_inc, age_clr, age_sat;
  logic [AGE_W-1:0] age_count;

  assign in_idle = (state_q == ARB_IDLE);
  assign any_req = m0_req || m1_req;
  assign take_m1 = pick_m1(m0_req, m1_req, age_sat);

  // Age only moves while arbitrating: it counts M1 losses and resets on an M1
  // grant or whenever M1 stops asking, so a stale count can never force M1 later.
  assign age_inc = in_idle && m1_req && m0_req && !take_m1;
  assign age_clr = in_idle && (!m1_req || take_m1);

  arb_age_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_age (
    .clk   (clk),
    .rst_n (reset),
    .inc   (age_inc),
    .clr   (age_clr),
    .count (age_count),
    .sat   (age_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (any_req) state_d = ARB_ISSUE;
      ARB_ISSUE: state_d = ARB_RESP;
      ARB_RESP:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // Payload and owner are frozen at grant so the masters may change or drop
  // their request lines while the transaction is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q   <= '0;
      owner_q <= ARB_M0;
    end else if (in_idle && any_req) begin
      owner_q <= take_m1 ? ARB_M1 : ARB_M0;
      if (take_m1) begin
        req_q <= '{addr: m1_addr, wdata: m1_wdata, byteen: m1_byteen};
      end else begin
        req_q <= '{addr: m0_addr, wdata: m0_wdata, byteen: m0_byteen};
      end
    end
  end

  // Decoder data is only meaningful during ISSUE; capture it there for the ack cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (state_q == ARB_ISSUE) begin
      rdata_q <= bus_rdata;
    end
  end

  // Outputs decode straight from the state register so an async reset clears
  // the bus and acks in the same cycle.
  assign bus_valid  = (state_q == ARB_ISSUE);
  assign bus_addr   = bus_valid ? req_q.addr   : 32'h0;
  assign bus_wdata  = bus_valid ? req_q.wdata  : 32'h0;
  assign bus_byteen = bus_valid ? req_q.byteen : 4'h0;
  assign bus_owner  = owner_q;
  assign busy       = !in_idle;

  assign m0_ack   = (state_q == ARB_RESP) && (owner_q == ARB_M0);
  assign m1_ack   = (state_q == ARB_RESP) && (owner_q == ARB_M1);
  assign m0_rdata = m0_ack ? rdata_q : 32'h0;
  assign m1_rdata = m1_ack ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_byteen, m1_byteen;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        bus_valid, bus_owner, busy;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_byteen;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        owner;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } txn_t;

  txn_t exp_q[$];   // expected bus transactions, in grant order
  txn_t ack_q[$];   // transactions seen on the bus, awaiting their ack
  txn_t mon_t;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byteen(bus_byteen),
    .bus_rdata(bus_rdata), .bus_owner(bus_owner), .busy(busy)
  );

  // Decoder model: fixed pattern per address, garbage when the bus is idle.
  function automatic logic [31:0] dec(input logic [31:0] a);
    return (a == 32'h0000_0010) ? 32'h1234_5678 : (a ^ 32'h5A5A_0F0F);
  endfunction

  assign bus_rdata = bus_valid ? dec(bus_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic own, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    txn_t t;
    t.owner = own; t.addr = a; t.wdata = wd; t.byteen = be;
    exp_q.push_back(t);
  endtask

  function automatic logic [31:0] age();
    return 32'(dut.u_age.count);
  endfunction

  // Scoreboard monitor: bus side pops exp_q, ack side pops ack_q.
  always @(negedge clk) begin
    if (reset) begin
      if (bus_valid) begin
        if (exp_q.size() == 0) begin
          chk("bus_spurious", 32'(bus_valid), 32'h0);
        end else begin
          mon_t = exp_q.pop_front();
          chk("bus_owner",  32'(bus_owner),  32'(mon_t.owner));
          chk("bus_addr",   bus_addr,        mon_t.addr);
          chk("bus_wdata",  bus_wdata,       mon_t.wdata);
          chk("bus_byteen", 32'(bus_byteen), 32'(mon_t.byteen));
          ack_q.push_back(mon_t);
        end
      end else begin
        chk("idle_bus", {bus_addr | bus_wdata} | 32'(bus_byteen), 32'h0);
      end
      if (m0_ack || m1_ack) begin
        if (ack_q.size() == 0) begin
          chk("ack_spurious", {30'h0, m1_ack, m0_ack}, 32'h0);
        end else begin
          mon_t = ack_q.pop_front();
          chk("ack_which", {30'h0, m1_ack, m0_ack}, mon_t.owner ? 32'h2 : 32'h1);
          chk("ack_rdata", m0_rdata | m1_rdata, dec(mon_t.addr));
        end
      end else begin
        chk("rdata_noack", m0_rdata | m1_rdata, 32'h0);
      end
    end
  end

  initial begin
    int acks, m0_cnt;
    bit got;
    reset = 1'b0;
    m0_req = 0; m0_addr = 0; m0_wdata = 0; m0_byteen = 0;
    m1_req = 0; m1_addr = 0; m1_wdata = 0; m1_byteen = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {26'h0, bus_valid, bus_owner, busy, m0_ack, m1_ack, |bus_byteen}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    reset = 1'b1;

    // Idle, no requests: nothing on the bus and age stays zero.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_valid_busy", {30'h0, bus_valid, busy}, 32'h0);
      chk("idle_age", age(), 32'h0);
    end

    // M0 read of 0x10: bus one cycle after sampling, ack the cycle after.
    m0_req = 1; m0_addr = 32'h0000_0010; m0_byteen = 4'h0;
    push(ARB_M0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    chk("t2_bus_valid", 32'(bus_valid), 32'h1);
    m0_req = 0;
    @(negedge clk);
    chk("t2_m0_ack", 32'(m0_ack), 32'h1);
    chk("t2_m0_rdata", m0_rdata, 32'h1234_5678);
    @(negedge clk);
    chk("t2_done", {30'h0, busy, m0_ack}, 32'h0);

    // M1 write whose request is dropped and payload scrambled after grant.
    m1_req = 1; m1_addr = 32'h7F00; m1_wdata = 32'hCAFE_BABE; m1_byteen = 4'hF;
    push(ARB_M1, 32'h7F00, 32'hCAFE_BABE, 4'hF);
    @(negedge clk);
    chk("t4_bus_valid", 32'(bus_valid), 32'h1);
    m1_req = 0; m1_addr = 32'hFFFF_FFFF; m1_wdata = 32'h0; m1_byteen = 4'h0;
    @(negedge clk);
    chk("t4_m1_ack", 32'(m1_ack), 32'h1);
    @(negedge clk);
    chk("t4_done", {30'h0, busy, m1_ack}, 32'h0);

    // M0 holds req through ack: a second transaction follows.
    m0_req = 1; m0_addr = 32'h200; m0_wdata = 32'h0; m0_byteen = 4'h0;
    push(ARB_M0, 32'h200, 32'h0, 4'h0);
    push(ARB_M0, 32'h200, 32'h0, 4'h0);
    acks = 0;
    for (int c = 0; c < 20 && acks < 2; c++) begin
      @(negedge clk);
      if (m0_ack) begin
        acks++;
        if (acks == 2) m0_req = 0;
      end
    end
    chk("t5_ack_count", 32'(acks), 32'h2);
    @(negedge clk);
    chk("t5_idle", 32'(busy), 32'h0);

    // Contention: M0 wins 8 times, the 9th grant is forced to M1.
    m0_req = 1; m0_addr = 32'h300; m0_byteen = 4'h0;
    m1_req = 1; m1_addr = 32'h400; m1_wdata = 32'h0; m1_byteen = 4'h0;
    for (int i = 0; i < 8; i++) push(ARB_M0, 32'h300, 32'h0, 4'h0);
    push(ARB_M1, 32'h400, 32'h0, 4'h0);
    m0_cnt = 0; got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (bus_valid && bus_owner) chk("t3_age_after_m1", age(), 32'h0);
      if (m0_ack) begin
        m0_cnt++;
        if (m0_cnt == 8) chk("t3_age_sat", age(), 32'h8);
      end
      if (m1_ack) begin
        got = 1; m0_req = 0; m1_req = 0;
      end
    end
    chk("t3_m1_granted", 32'(got), 32'h1);
    chk("t3_m0_wins", 32'(m0_cnt), 32'h8);
    @(negedge clk);
    chk("t3_idle", {30'h0, busy, bus_valid}, 32'h0);

    // Reset asserted mid-ISSUE: bus and acks drop immediately, no ack afterwards.
    m0_req = 1; m0_addr = 32'h500; m0_wdata = 32'h11; m0_byteen = 4'h3;
    push(ARB_M0, 32'h500, 32'h11, 4'h3);
    @(negedge clk);
    chk("t1_in_issue", 32'(bus_valid), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("t1_bus_drop", {28'h0, bus_valid, m0_ack, m1_ack, busy}, 32'h0);
    chk("t1_byteen", 32'(bus_byteen), 32'h0);
    m0_req = 0;
    exp_q.delete();
    ack_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t1_state_idle", 32'(dut.state_q), 32'(ARB_IDLE));
    repeat (3) @(negedge clk);
    chk("t1_no_late_ack", {30'h0, m0_ack, m1_ack}, 32'h0);

    chk("end_exp_q", 32'(exp_q.size()), 32'h0);
    chk("end_ack_q", 32'(ack_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
